fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Shares one synchronous FIFO write port between NUM_REQ producers. Packet-aware
//  round-robin arbiter: a grant is held for a whole packet (until req_last) or
//  MAX_BEATS beats, whichever comes first. Drives FIFO write/data_in and honours
//  the FIFO full flag. Sits directly in front of the FIFO write side.
// PARAMETERS
//  NUM_REQ    4   number of producers, >=2
//  WIDTH      8   data width, equals FIFO WIDTH
//  MAX_BEATS  16  max beats per grant before forced re-arbitration, >=1
// PORTS
//  clk           in   1                  clock, all logic on posedge
//  rst_n         in   1                  synchronous reset, active-low
//  req_valid     in   NUM_REQ            producer i has a beat
//  req_last      in   NUM_REQ            beat i is last of packet
//  req_data      in   NUM_REQ*WIDTH      producer i data at [i*WIDTH +: WIDTH]
//  req_ready     out  NUM_REQ            beat i accepted this cycle
//  fifo_full     in   1                  FIFO full flag
//  fifo_write    out  1                  FIFO write strobe
//  fifo_data_in  out  WIDTH              FIFO write data
//  grant_id      out  $clog2(NUM_REQ)    current owner, valid when busy=1
//  busy          out  1                  state == BURST
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0.
//   Outputs while in reset: req_ready=0, fifo_write=0, busy=0.
//   Reset mid-burst aborts the packet; no write in the reset cycle; no flush.
//  FSM, 2 states:
//   IDLE : if any req_valid -> grant_id <= first requester with valid at or after
//          rr_ptr (cyclic), beat_cnt<=0, -> BURST. No valid -> stay.
//          No beat is accepted in IDLE (1-cycle arbitration bubble).
//   BURST: beat accepted when req_valid[grant_id] & ~fifo_full.
//          On accept: beat_cnt++; if req_last[grant_id] or beat_cnt==MAX_BEATS-1
//          -> IDLE, rr_ptr <= grant_id+1 (wraps NUM_REQ-1 -> 0).
//          No accept -> stay, counters unchanged.
//  Combinational outputs:
//   fifo_write   = busy & req_valid[grant_id] & ~fifo_full
//   req_ready[i] = fifo_write & (grant_id==i); all others 0
//   fifo_data_in = req_data slice of grant_id (don't-care when fifo_write=0)
//  Boundaries:
//   - fifo_full=1: no write, no ready, grant held; resumes same cycle full drops.
//   - valid gap from owner mid-packet: grant held indefinitely (no timeout).
//   - MAX_BEATS split: packet tail re-arbitrates like a new request.
//   - last on MAX_BEATS-th beat: single return to IDLE, no double advance.
//   - non-owner valid during BURST: ignored; producers must hold data/valid.
//   - single active requester: back-to-back packets with 1 idle cycle between.
//  Width: beat_cnt $clog2(MAX_BEATS+1) bits, never exceeds MAX_BEATS-1.
// STRUCTURE
//  Package fifo_arb_pkg: typedef enum logic {IDLE, BURST} arb_state_t;
//   function rr_pick helpers and default parameter constants.
//  Sub-module rr_arbiter: combinational cyclic priority pick (req vector,
//   rr_ptr -> grant index, any_req). Top holds FSM, counters, muxing.
// TESTING
//  1 req0 3-beat pkt (A1,A2,A3,last on A3), full=0 -> grant 0 at cycle 1,
//    writes A1..A3 cycles 2-4, busy=0 cycle 5, rr_ptr=1.
//  2 req0 and req2 valid together from reset -> req0 packet first, then req2;
//    next contention req0/req2 with rr_ptr=1 -> req2 wins.
//  3 fifo_full=1 for 3 cycles mid-packet -> fifo_write=0, req_ready=0, grant
//    and beat_cnt held; data order intact after release.
//  4 MAX_BEATS=4, req1 sends 6-beat pkt, req3 idle -> 4 writes, IDLE bubble,
//    req1 re-granted, remaining 2 written; with req3 valid, req3 wins at split.
//  5 rst_n=0 for 1 cycle after beat 2 of 5 -> no write that cycle, state IDLE,
//    rr_ptr=0, re-arbitration starts from requester 0.
//  6 owner drops valid 2 cycles mid-packet while req2 valid -> grant stays;
//    req2 gets no ready until owner's last beat.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types, default parameters and helpers for the packet-aware FIFO write arbiter.
package fifo_arb_pkg;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_WIDTH     = 8;
    localparam int DEF_MAX_BEATS = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Requester index visited at position 'off' of a cyclic scan starting at 'ptr'.
    function automatic int unsigned rr_pick_idx(input int unsigned ptr,
                                                input int unsigned off,
                                                input int unsigned n);
        return (ptr + off) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational cyclic-priority pick: first asserted request at or after ptr.
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N = DEF_NUM_REQ
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] grant,
    output logic                 any_req
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] idx;

    assign any_req = |req;

    // Scan from the farthest offset down so the nearest requester overwrites last.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = IW'(rr_pick_idx(int'(ptr), i, N));
            if (req[idx]) begin
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-aware round-robin arbiter sharing one FIFO write port between NUM_REQ producers.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_BEATS = DEF_MAX_BEATS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_last,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       fifo_full,
    output logic                       fifo_write,
    output logic [WIDTH-1:0]           fifo_data_in,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BEATS + 1);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;

    logic [IW-1:0] pick;
    logic          any_req;
    logic          end_of_grant;
    logic [IW-1:0] grant_plus1;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .grant   (pick),
        .any_req (any_req)
    );

    // Outputs are gated by reset so a reset landing mid-burst writes nothing.
    assign busy         = rst_n && (state_q == BURST);
    assign fifo_write   = busy && req_valid[grant_q] && !fifo_full;
    assign fifo_data_in = req_data[grant_q*WIDTH +: WIDTH];
    assign grant_id     = grant_q;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = fifo_write && (grant_q == IW'(gi));
        end
    endgenerate

    assign end_of_grant = req_last[grant_q] || (beat_cnt_q == CW'(MAX_BEATS - 1));
    assign grant_plus1  = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d    = pick;
                    beat_cnt_d = '0;
                    state_d    = BURST;
                end
            end
            BURST: begin
                if (fifo_write) begin
                    if (end_of_grant) begin
                        // Counter parks at zero so it never reaches MAX_BEATS.
                        beat_cnt_d = '0;
                        rr_ptr_d   = grant_plus1;
                        state_d    = IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench: producer queues drive the arbiter, expected writes are queued per test.
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int WIDTH     = 8;
    localparam int MAX_BEATS = 4;

    typedef struct packed {
        logic             last;
        logic [WIDTH-1:0] data;
    } beat_t;

    typedef struct packed {
        logic [1:0]       id;
        logic [WIDTH-1:0] data;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [NUM_REQ-1:0]       req_valid = '0;
    logic [NUM_REQ-1:0]       req_last = '0;
    logic [NUM_REQ*WIDTH-1:0] req_data = '0;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     fifo_full = 1'b0;
    logic                     fifo_write;
    logic [WIDTH-1:0]         fifo_data_in;
    logic [1:0]               grant_id;
    logic                     busy;

    beat_t              prod_q[NUM_REQ][$];
    exp_t               exp_q[$];
    logic [NUM_REQ-1:0] mask = '1;

    logic               snap_write, snap_busy;
    logic [NUM_REQ-1:0] snap_ready;
    logic [1:0]         snap_grant;

    int tests_run = 0;
    int failed    = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .WIDTH     (WIDTH),
        .MAX_BEATS (MAX_BEATS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_last     (req_last),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_write   (fifo_write),
        .fifo_data_in (fifo_data_in),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    task automatic drive_inputs();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (mask[i] && prod_q[i].size() > 0) begin
                req_valid[i]               = 1'b1;
                req_last[i]                = prod_q[i][0].last;
                req_data[i*WIDTH +: WIDTH] = prod_q[i][0].data;
            end else begin
                req_valid[i]               = 1'b0;
                req_last[i]                = 1'b0;
                req_data[i*WIDTH +: WIDTH] = '0;
            end
        end
    endtask

    task automatic load(input int id, input logic [WIDTH-1:0] base, input int n);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.data = base + WIDTH'(k);
            b.last = (k == n - 1);
            prod_q[id].push_back(b);
        end
    endtask

    task automatic expect_beats(input int id, input logic [WIDTH-1:0] base, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.id   = 2'(id);
            e.data = base + WIDTH'(k);
            exp_q.push_back(e);
        end
    endtask

    // One clock: sample at negedge, score any write, then retire accepted beats.
    task automatic cycle();
        logic [NUM_REQ-1:0] rdy;
        logic [NUM_REQ-1:0] oh;
        exp_t e;
        @(negedge clk);
        snap_write = fifo_write;
        snap_busy  = busy;
        snap_ready = req_ready;
        snap_grant = grant_id;
        rdy        = req_ready;
        tests_run++;
        if (fifo_write === 1'b1) begin
            if (exp_q.size() == 0) begin
                failed++;
                $display("FAIL sb_unexpected_write: got id=%0d data=%h, required no write", grant_id, fifo_data_in);
            end else begin
                e  = exp_q.pop_front();
                oh = '0;
                oh[e.id] = 1'b1;
                if (grant_id !== e.id || fifo_data_in !== e.data || req_ready !== oh)
                begin
                    failed++;
                    $display("FAIL sb_write: got id=%0d data=%h ready=%b, required id=%0d data=%h ready=%b",
                             grant_id, fifo_data_in, req_ready, e.id, e.data, oh);
                end else begin
                    $display("[TB] write id=%0d data=%h", grant_id, fifo_data_in);
                end
            end
        end else if (req_ready !== '0 || fifo_write !== 1'b0) begin
            failed++;
            $display("FAIL sb_idle_outputs: got write=%b ready=%b, required write=0 ready=0", fifo_write, req_ready);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rdy[i] && prod_q[i].size() > 0) begin
                void'(prod_q[i].pop_front());
            end
        end
        drive_inputs();
    endtask

    task automatic run_until_idle(input string name, input int budget);
        int  n;
        bit  done;
        n    = 0;
        done = 0;
        while (!done && n < budget) begin
            cycle();
            n++;
            done = (exp_q.size() == 0) && !snap_busy;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (prod_q[i].size() > 0) done = 0;
            end
        end
        tests_run++;
        if (!done) begin
            failed++;
            $display("FAIL %s_timeout: got %0d expected writes outstanding after %0d cycles, required 0", name, exp_q.size(), budget);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        fifo_full = 1'b0;
        mask      = '1;
        for (int i = 0; i < NUM_REQ; i++) prod_q[i].delete();
        exp_q.delete();
        drive_inputs();
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        load(3, 8'h30, 1);
        expect_beats(3, 8'h30, 1);
        drive_inputs();
        for (int c = 0; c < 3; c++) begin
            cycle();
            tests_run++;
            if (snap_busy !== 1'b0 || snap_write !== 1'b0 || snap_ready !== '0) begin
                failed++;
                $display("FAIL reset_outputs: got busy=%b write=%b ready=%b, required 0/0/0", snap_busy, snap_write, snap_ready);
            end
        end
        tests_run++;
        if (snap_grant !== 2'd0 || dut.rr_ptr_q !== 2'd0) begin
            failed++;
            $display("FAIL reset_state: got grant=%0d rr_ptr=%0d, required 0/0", snap_grant, dut.rr_ptr_q);
        end
        rst_n = 1'b1;
        run_until_idle("reset_wrap", 20);
        tests_run++;
        if (dut.rr_ptr_q !== 2'd0) begin
            failed++;
            $display("FAIL rr_ptr_wrap: got %0d, required 0", dut.rr_ptr_q);
        end
    endtask

    task automatic test_single_packet();
        do_reset();
        load(0, 8'hA1, 3);
        expect_beats(0, 8'hA1, 3);
        drive_inputs();
        cycle();
        tests_run++;
        if (snap_busy !== 1'b0) begin
            failed++;
            $display("FAIL arb_bubble: got busy=%b, required 0", snap_busy);
        end
        cycle();
        tests_run++;
        if (snap_busy !== 1'b1 || snap_grant !== 2'd0 || snap_write !== 1'b1) begin
            failed++;
            $display("FAIL first_grant: got busy=%b grant=%0d write=%b, required 1/0/1", snap_busy, snap_grant, snap_write);
        end
        cycle();
        cycle();
        cycle();
        tests_run++;
        if (snap_busy !== 1'b0 || dut.rr_ptr_q !== 2'd1) begin
            failed++;
            $display("FAIL pkt_end: got busy=%b rr_ptr=%0d, required 0/1", snap_busy, dut.rr_ptr_q);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        load(0, 8'h01, 2);
        load(2, 8'h21, 2);
        expect_beats(0, 8'h01, 2);
        expect_beats(2, 8'h21, 2);
        drive_inputs();
        run_until_idle("rr_first", 30);
        load(0, 8'h05, 1);
        expect_beats(0, 8'h05, 1);
        drive_inputs();
        run_until_idle("rr_single", 30);
        load(0, 8'h09, 2);
        load(2, 8'h29, 2);
        expect_beats(2, 8'h29, 2);
        expect_beats(0, 8'h09, 2);
        drive_inputs();
        run_until_idle("rr_second", 30);
    endtask

    task automatic test_fifo_full();
        do_reset();
        load(1, 8'hB1, 4);
        expect_beats(1, 8'hB1, 4);
        drive_inputs();
        cycle();
        cycle();
        fifo_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cycle();
            tests_run++;
            if (snap_write !== 1'b0 || snap_ready !== '0 || snap_busy !== 1'b1 ||
                snap_grant !== 2'd1 || dut.beat_cnt_q !== 3'd1) begin
                failed++;
                $display("FAIL full_hold: got write=%b ready=%b busy=%b grant=%0d cnt=%0d, required 0/0000/1/1/1",
                         snap_write, snap_ready, snap_busy, snap_grant, dut.beat_cnt_q);
            end
        end
        fifo_full = 1'b0;
        cycle();
        tests_run++;
        if (snap_write !== 1'b1) begin
            failed++;
            $display("FAIL full_resume: got write=%b, required 1", snap_write);
        end
        run_until_idle("full", 30);
    endtask

    task automatic test_max_beats();
        do_reset();
        load(1, 8'hC1, 6);
        expect_beats(1, 8'hC1, 6);
        drive_inputs();
        for (int c = 0; c < 5; c++) cycle();
        cycle();
        tests_run++;
        if (snap_busy !== 1'b0) begin
            failed++;
            $display("FAIL split_bubble: got busy=%b, required 0", snap_busy);
        end
        cycle();
        tests_run++;
        if (snap_busy !== 1'b1 || snap_grant !== 2'd1) begin
            failed++;
            $display("FAIL split_regrant: got busy=%b grant=%0d, required 1/1", snap_busy, snap_grant);
        end
        run_until_idle("split", 30);
        load(0, 8'hD1, 4);
        expect_beats(0, 8'hD1, 4);
        drive_inputs();
        run_until_idle("last_at_max", 30);
        tests_run++;
        if (dut.rr_ptr_q !== 2'd1 || dut.beat_cnt_q !== 3'd0) begin
            failed++;
            $display("FAIL last_at_max: got rr_ptr=%0d cnt=%0d, required 1/0", dut.rr_ptr_q, dut.beat_cnt_q);
        end
        do_reset();
        load(1, 8'hE1, 6);
        load(3, 8'hF1, 2);
        expect_beats(1, 8'hE1, 4);
        expect_beats(3, 8'hF1, 2);
        expect_beats(1, 8'hE5, 2);
        drive_inputs();
        run_until_idle("split_contend", 40);
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        load(1, 8'h11, 1);
        expect_beats(1, 8'h11, 1);
        drive_inputs();
        run_until_idle("pre_reset", 20);
        load(2, 8'h61, 5);
        load(0, 8'h71, 2);
        expect_beats(2, 8'h61, 2);
        expect_beats(0, 8'h71, 2);
        expect_beats(2, 8'h63, 3);
        drive_inputs();
        cycle();
        cycle();
        cycle();
        rst_n = 1'b0;
        cycle();
        tests_run++;
        if (snap_write !== 1'b0 || snap_busy !== 1'b0 || snap_ready !== '0) begin
            failed++;
            $display("FAIL reset_mid: got write=%b busy=%b ready=%b, required 0/0/0", snap_write, snap_busy, snap_ready);
        end
        rst_n = 1'b1;
        tests_run++;
        if (dut.rr_ptr_q !== 2'd0) begin
            failed++;
            $display("FAIL reset_mid_ptr: got %0d, required 0", dut.rr_ptr_q);
        end
        run_until_idle("reset_mid", 40);
    endtask

    task automatic test_valid_gap();
        do_reset();
        load(1, 8'h81, 4);
        load(2, 8'h91, 2);
        expect_beats(1, 8'h81, 4);
        expect_beats(2, 8'h91, 2);
        drive_inputs();
        cycle();
        cycle();
        cycle();
        mask[1] = 1'b0;
        drive_inputs();
        for (int c = 0; c < 2; c++) begin
            cycle();
            tests_run++;
            if (snap_write !== 1'b0 || snap_busy !== 1'b1 || snap_grant !== 2'd1 || snap_ready !== '0) begin
                failed++;
                $display("FAIL gap_hold: got write=%b busy=%b grant=%0d ready=%b, required 0/1/1/0000",
                         snap_write, snap_busy, snap_grant, snap_ready);
            end
        end
        mask[1] = 1'b1;
        drive_inputs();
        run_until_idle("gap", 30);
    endtask

    initial begin
        drive_inputs();
        test_reset();
        test_single_packet();
        test_round_robin();
        test_fifo_full();
        test_max_beats();
        test_reset_mid_burst();
        test_valid_gap();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
